counter_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one up/down counter (rst_n/inc/dec/clk ->

---
 rtl/counter_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sequencer sharing one up/down counter among NREQ requesters.
// Define COUNTER_ARB_WRAP_EN to drop the bound check and let the counter wrap.
module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          dir,
  input  logic [WIDTH-1:0]         count_in,
  output logic                     inc,
  output logic                     dec,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          nack,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int GW = $clog2(NREQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] REFUSE = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic          gdir;
  logic [GW-1:0] win;
  logic          refuse;

  // Index base+off modulo NREQ; off never exceeds NREQ so one subtraction suffices.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[GW-1:0];
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_idx(rr_ptr, k)]) win = rr_idx(rr_ptr, k);
    end
  end

`ifdef COUNTER_ARB_WRAP_EN
  logic unused_count;
  assign unused_count = ^count_in;
  assign refuse = 1'b0;
`else
  assign refuse = dir[win] ? (count_in == {WIDTH{1'b1}}) : (count_in == {WIDTH{1'b0}});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= GW'(NREQ - 1);
      grant_id <= '0;
      gdir     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= win;
            gdir     <= dir[win];
            state    <= refuse ? REFUSE : ISSUE;
          end
        end
        ISSUE: state <= SETTLE;
        SETTLE, REFUSE: begin
          rr_ptr <= grant_id;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode purely from state registers, never from req/dir/count_in.
  always_comb begin
    inc  = (state == ISSUE) &  gdir;
    dec  = (state == ISSUE) & ~gdir;
    busy = (state != IDLE);
    ack  = '0;
    nack = '0;
    if (state == SETTLE) ack[grant_id] = 1'b1;
`ifndef COUNTER_ARB_WRAP_EN
    if (state == REFUSE) nack[grant_id] = 1'b1;
`endif
  end

endmodule
